mem_bus_master: RTL and testbench

- Initiator side of the 4-bit-address / 8-bit bidirectional-data memory interface (address_bus, mem_enable, read_write, data_bus).
- Accepts single read/write requests from the CPU-side datapath via a valid/ready handshake.
- Sequences the memory pins through setup, access and turnaround phases, and returns read data with a one-cycle response pulse.
- Owns tristate control of data_bus on the master side, so the bus is never driven by both ends at once.

---
 rtl/mem_bus_master_if.sv | 25 ++
 rtl/mem_bus_master.sv | 100 ++++++++++
 tb/tb_mem_bus_master.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_master_if.sv
// CPU-side request/response channel of the memory bus master.
// The master modport is the bus master itself; slave is the requesting datapath.
interface mem_bus_master_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              busy;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, busy
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, busy
    );
endinterface

// File: rtl/mem_bus_master.sv
// Initiator for the 4-bit address / 8-bit bidirectional data memory interface.
// Single outstanding access, sequenced as setup, access and a dead turnaround cycle.
//
// state  | meaning
// IDLE   | waiting for a request, bus released, req_ready high
// SETUP  | address and direction presented, write data driven, enable low
// ACCESS | mem_enable high for RD_LAT / WR_LAT cycles
// TURN   | enable low, bus released, rsp_valid pulse
module mem_bus_master #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1,
    parameter int WR_LAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    mem_bus_master_if.master    cpu,
    output logic [ADDR_W-1:0]   address_bus,
    output logic                mem_enable,
    output logic                read_write,
    inout  wire  [DATA_W-1:0]   data_bus
);
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, TURN} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr_q;
    logic              write_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [CNT_W-1:0]  cnt;
    logic              accept;
    logic              drive_bus;
    logic              last_beat;

    assign accept    = (state == IDLE) && cpu.req_valid;
    assign last_beat = (cnt <= CNT_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = SETUP;
            SETUP:   state_nx = ACCESS;
            ACCESS:  if (last_beat) state_nx = TURN;
            TURN:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        cpu.req_ready = (state == IDLE) && !reset;
        cpu.busy      = (state != IDLE);
        cpu.rsp_valid = (state == TURN);
        mem_enable    = (state == ACCESS);
        read_write    = 1'b1;
        drive_bus     = 1'b0;
        if (state == SETUP || state == ACCESS) begin
            read_write = !write_q;
            drive_bus  = write_q;
        end
    end

    // Request fields are frozen at acceptance; the CPU may change its inputs afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt     <= '0;
        end else begin
            if (accept) begin
                addr_q  <= cpu.req_addr;
                write_q <= cpu.req_write;
                wdata_q <= cpu.req_wdata;
            end
            case (state)
                SETUP:   cnt <= write_q ? CNT_W'(WR_LAT) : CNT_W'(RD_LAT);
                ACCESS: begin
                    cnt <= cnt - CNT_W'(1);
                    if (last_beat && !write_q)
                        rdata_q <= data_bus;
                end
                default: cnt <= cnt;
            endcase
        end
    end

    assign address_bus   = addr_q;
    assign cpu.rsp_rdata = rdata_q;
    assign data_bus      = drive_bus ? wdata_q : {DATA_W{1'bz}};
endmodule

// File: tb/tb_mem_bus_master.sv
// Scoreboard bench for mem_bus_master with an attached behavioural memory.
module tb_mem_bus_master;
    localparam int AW     = 4;
    localparam int DW     = 8;
    localparam int RD_LAT = 3;
    localparam int WR_LAT = 1;

    typedef struct {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            acc;
    } req_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_bus_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

    logic [AW-1:0] address_bus;
    logic          mem_enable;
    logic          read_write;
    wire  [DW-1:0] data_bus;

    mem_bus_master #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu         (bus_if),
        .address_bus (address_bus),
        .mem_enable  (mem_enable),
        .read_write  (read_write),
        .data_bus    (data_bus)
    );

    // Memory device on the pins
    logic [DW-1:0] mem [16];
    assign data_bus = (mem_enable && read_write) ? mem[address_bus] : {DW{1'bz}};
    always @(posedge clk) if (mem_enable && !read_write) mem[address_bus] = data_bus;

    // Reference model state
    logic [DW-1:0] ref_mem [16];
    logic [DW-1:0] ref_last_rd = '0;
    req_t q[$];
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int prev_acc = 0;
    int prev_lat = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic released();
        return (data_bus === {DW{1'bz}}) || (data_bus === {DW{1'b0}});
    endfunction

    // Monitor: the oldest outstanding request defines what the pins must show this cycle
    req_t e;
    int   ph;
    int   lat;
    always @(negedge clk) begin
        if (!reset) begin
            if (q.size() == 0) begin
                chk("idle_enable", 32'(mem_enable), 32'd0);
                chk("idle_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
                chk("idle_busy", 32'(bus_if.busy), 32'd0);
                chk("idle_rw", 32'(read_write), 32'd1);
                chk("idle_ready", 32'(bus_if.req_ready), 32'd1);
                chk("idle_bus_released", 32'(released()), 32'd1);
                chk("rdata_hold", 32'(bus_if.rsp_rdata), 32'(ref_last_rd));
            end else begin
                e   = q[0];
                lat = e.w ? WR_LAT : RD_LAT;
                ph  = cyc - e.acc;
                chk("busy", 32'(bus_if.busy), 32'd1);
                chk("ready_when_busy", 32'(bus_if.req_ready), 32'd0);
                chk("enable_phase", 32'(mem_enable), 32'(ph >= 1 && ph <= lat));
                chk("rsp_valid_phase", 32'(bus_if.rsp_valid), 32'(ph == lat + 1));
                if (ph <= lat) begin
                    chk("address", 32'(address_bus), 32'(e.a));
                    chk("direction", 32'(read_write), 32'(!e.w));
                    if (e.w)
                        chk("write_data_on_bus", 32'(data_bus), 32'(e.d));
                    else if (ph >= 1)
                        chk("read_bus_no_contention", 32'(data_bus), 32'(ref_mem[e.a]));
                end else begin
                    chk("turn_rw", 32'(read_write), 32'd1);
                    chk("turn_bus_released", 32'(released()), 32'd1);
                    if (e.w) begin
                        chk("write_rdata_unchanged", 32'(bus_if.rsp_rdata), 32'(ref_last_rd));
                        ref_mem[e.a] = e.d;
                    end else begin
                        chk("read_rdata", 32'(bus_if.rsp_rdata), 32'(ref_mem[e.a]));
                        ref_last_rd = ref_mem[e.a];
                    end
                    void'(q.pop_front());
                end
            end
        end
    end

    // Present a request from a negedge until accepted; returns on the negedge after acceptance.
    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit b2b);
        bit done = 0;
        bit rdy;
        int pre;
        bus_if.req_valid = 1'b1;
        bus_if.req_write = w;
        bus_if.req_addr  = a;
        bus_if.req_wdata = d;
        for (int t = 0; t < 60 && !done; t++) begin
            rdy = bus_if.req_ready;
            pre = cyc;
            @(posedge clk);
            if (rdy) begin
                q.push_back('{w: w, a: a, d: d, acc: pre + 1});
                if (b2b) chk("b2b_interval", 32'(pre + 1 - prev_acc), 32'(3 + prev_lat));
                prev_acc = pre + 1;
                prev_lat = w ? WR_LAT : RD_LAT;
                done = 1;
            end
            @(negedge clk);
        end
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        bus_if.req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        bus_if.req_valid = 1'b0;
        for (int t = 0; t < 60 && q.size() != 0; t++) @(negedge clk);
        chk("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
        mem[5]  = 8'h00;
        mem[3]  = 8'h77;
        mem[10] = 8'hC3;
        for (int i = 0; i < 16; i++) ref_mem[i] = mem[i];
        bus_if.req_valid = 1'b0;
        bus_if.req_write = 1'b0;
        bus_if.req_addr  = '0;
        bus_if.req_wdata = '0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_address", 32'(address_bus), 32'd0);
        chk("rst_enable", 32'(mem_enable), 32'd0);
        chk("rst_rw", 32'(read_write), 32'd1);
        chk("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        chk("rst_rdata", 32'(bus_if.rsp_rdata), 32'd0);
        chk("rst_busy", 32'(bus_if.busy), 32'd0);
        chk("rst_ready", 32'(bus_if.req_ready), 32'd0);
        chk("rst_bus_released", 32'(released()), 32'd1);
        @(negedge clk);
        #2 reset = 1'b0;

        // Idle protocol
        repeat (20) @(negedge clk);

        // Reset during a write ACCESS
        issue(1'b1, 4'd5, 8'h0F, 1'b0);
        bus_if.req_valid = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_enable", 32'(mem_enable), 32'd0);
        chk("abort_rw", 32'(read_write), 32'd1);
        chk("abort_busy", 32'(bus_if.busy), 32'd0);
        chk("abort_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        chk("abort_bus_released", 32'(released()), 32'd1);
        q.delete();
        ref_last_rd = '0;
        @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_no_write", 32'(mem[5]), 32'(ref_mem[5]));

        // Write then read back
        issue(1'b1, 4'd5, 8'h0F, 1'b0);
        idle(2);
        issue(1'b0, 4'd5, 8'h00, 1'b0);
        drain();
        chk("wr_rd_mem5", 32'(mem[5]), 32'h0F);
        chk("wr_rd_rdata", 32'(bus_if.rsp_rdata), 32'h0F);

        // Longer read latency
        issue(1'b0, 4'hA, 8'h00, 1'b0);
        drain();
        chk("rd_lat_rdata", 32'(bus_if.rsp_rdata), 32'hC3);

        // Back-to-back alternating write/read on 0xF
        for (int i = 0; i < 6; i++)
            issue(1'(i % 2 == 0), 4'hF, 8'($urandom), i > 0);
        drain();

        // Inputs changed after acceptance are ignored
        issue(1'b1, 4'd2, 8'h55, 1'b0);
        bus_if.req_valid = 1'b0;
        bus_if.req_addr  = 4'd3;
        bus_if.req_wdata = 8'hAA;
        drain();
        chk("stable_addr2", 32'(mem[2]), 32'h55);
        chk("stable_addr3", 32'(mem[3]), 32'h77);

        // Random traffic
        for (int i = 0; i < 40; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            if (gap != 0) idle(gap);
            issue(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom), gap == 0 && i > 0);
        end
        drain();

        for (int i = 0; i < 16; i++) chk("mem_final", 32'(mem[i]), 32'(ref_mem[i]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
